// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one external ALU between two requesters
// Optional opcode legality check enabled by defining ALU_ARB_OPCHECK_EN.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req0_ctrl,
  input  logic [3:0]       req1_ctrl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_illegal,
  output logic [3:0]       alu_control,
  output logic [WIDTH-1:0] alu_inp1,
  output logic [WIDTH-1:0] alu_inp2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   ptr;
  logic   owner;
  logic   gnt;
  logic   any_req;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    any_req = |req_valid;
    gnt     = ptr;
    if (req_valid == 2'b01) gnt = 1'b0;
    else if (req_valid == 2'b10) gnt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready[owner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rst_n gates req_ready so it reads 0 during reset even with requests pending.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (state == IDLE && any_req && rst_n) req_ready = {gnt, ~gnt};
    if (state == RESP) rsp_valid = {owner, ~owner};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= 1'b0;
      owner       <= 1'b0;
      alu_control <= 4'd0;
      alu_inp1    <= '0;
      alu_inp2    <= '0;
    end else if (state == IDLE && any_req) begin
      ptr         <= ~gnt;
      owner       <= gnt;
      alu_control <= gnt ? req1_ctrl : req0_ctrl;
      alu_inp1    <= gnt ? req1_a : req0_a;
      alu_inp2    <= gnt ? req1_b : req0_b;
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  logic op_legal;

  always_comb begin
    op_legal = (alu_control == 4'b0011) || (alu_control == 4'b0001) ||
               (alu_control == 4'b0010) || (alu_control == 4'b0100);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
    end else if (state == EXEC) begin
      rsp_result  <= op_legal ? alu_result : '0;
      rsp_zero    <= op_legal ? alu_zero : 1'b0;
      rsp_illegal <= ~op_legal;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else if (state == EXEC) begin
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
    end
  end

  assign rsp_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter
// Expectations follow ALU_ARB_OPCHECK_EN when it is defined for the build.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0]  req0_ctrl, req1_ctrl, alu_control;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] rsp_result, alu_inp1, alu_inp2, alu_result;
  logic        rsp_zero, rsp_illegal, alu_zero;

  int  total = 0;
  int  bad   = 0;
  logic ptr_m = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
    .alu_control(alu_control), .alu_inp1(alu_inp1), .alu_inp2(alu_inp2),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // External ALU; undefined opcodes return a recognisable garbage value.
  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0011: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0100: return a - b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_control, alu_inp1, alu_inp2);
  assign alu_zero   = (alu_result == 32'd0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] v,
                       input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                       input int hold);
    logic        g, ez, ei, legal;
    logic [3:0]  ec;
    logic [31:0] ea, eb, er;
    req_valid = v;
    req0_ctrl = c0; req0_a = a0; req0_b = b0;
    req1_ctrl = c1; req1_a = a1; req1_b = b1;
    g = (v == 2'b01) ? 1'b0 : (v == 2'b10) ? 1'b1 : ptr_m;
    ptr_m = ~g;
    ec = g ? c1 : c0;
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    legal = (ec == 4'b0011) || (ec == 4'b0001) || (ec == 4'b0010) || (ec == 4'b0100);
    er = alu_fn(ec, ea, eb);
    ez = (er == 32'd0);
    ei = 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
    if (!legal) begin
      er = 32'd0; ez = 1'b0; ei = 1'b1;
    end
`endif
    #1;
    check("grant", req_ready, g ? 2'b10 : 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    check("exec_req_ready", req_ready, 2'b00);
    check("exec_rsp_valid", rsp_valid, 2'b00);
    check("alu_control", alu_control, ec);
    check("alu_inp1", alu_inp1, ea);
    check("alu_inp2", alu_inp2, eb);
    @(negedge clk);
    check("rsp_valid", rsp_valid, g ? 2'b10 : 2'b01);
    check("rsp_result", rsp_result, er);
    check("rsp_zero", rsp_zero, ez);
    check("rsp_illegal", rsp_illegal, ei);
    for (int i = 0; i < hold; i++) begin
      req_valid = 2'b11;
      rsp_ready = g ? 2'b01 : 2'b10;
      #1;
      check("hold_req_ready", req_ready, 2'b00);
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, g ? 2'b10 : 2'b01);
      check("hold_rsp_result", rsp_result, er);
    end
    req_valid = 2'b00;
    rsp_ready = g ? 2'b10 : 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    check("after_rsp_valid", rsp_valid, 2'b00);
  endtask

  initial begin
    logic [3:0] ops [5];
    ops = '{4'b0011, 4'b0001, 4'b0010, 4'b0100, 4'b1111};
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req0_ctrl = 4'd0; req1_ctrl = 4'd0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    #1;
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_alu_control", alu_control, 4'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(2'b01, 4'b0010, 32'd5, 32'd7, 4'd0, 0, 0, 0);
    do_op(2'b01, 4'b0100, 32'd9, 32'd9, 4'd0, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      do_op(2'b11, 4'b0011, 32'hF0F0, 32'hFF00, 4'b0001, 32'h0F, 32'hF0, 0);
    do_op(2'b10, 4'd0, 0, 0, 4'b0100, 32'd3, 32'd5, 10);
    do_op(2'b01, 4'b0010, 32'hFFFF_FFFF, 32'd1, 4'd0, 0, 0, 0);
    do_op(2'b10, 4'd0, 0, 0, 4'b1111, 32'd3, 32'd4, 2);

    // Asynchronous reset in the middle of EXEC discards the operation.
    req_valid = 2'b01; req0_ctrl = 4'b0010; req0_a = 32'd1; req0_b = 32'd2;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_mid_rsp_valid", rsp_valid, 2'b00);
    check("rst_mid_result", rsp_result, 32'd0);
    check("rst_mid_zero", rsp_zero, 1'b0);
    check("rst_mid_illegal", rsp_illegal, 1'b0);
    check("rst_mid_ctrl", alu_control, 4'd0);
    check("rst_mid_inp1", alu_inp1, 32'd0);
    check("rst_mid_inp2", alu_inp2, 32'd0);
    req_valid = 2'b00;
    ptr_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle_valid", rsp_valid, 2'b00);
      check("post_rst_idle_ready", req_ready, 2'b00);
    end

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  v;
      logic [31:0] a0, a1;
      v  = 2'($urandom_range(1, 3));
      a0 = $urandom;
      a1 = $urandom;
      do_op(v, ops[$urandom_range(0, 4)], a0, ($urandom_range(0, 3) == 0) ? a0 : $urandom,
               ops[$urandom_range(0, 4)], a1, ($urandom_range(0, 3) == 0) ? a1 : $urandom,
               $urandom_range(0, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
